ahb_cache_arbiter: RTL and testbench

Two-port AHB-Lite arbiter that lets two read masters share one downstream AHB-Lite slave, typically an instruction fetch port and a data port in front of the shared read-only cache. Uncontended requests pass through with zero added latency. A request that loses arbitration is captured in a one-entry per-port buffer, and that port's data phase is stalled until the request has been issued and completed downstream.

---
 rtl/ahb_cache_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ahb_cache_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cache_arbiter.sv
// Two-port AHB-Lite read arbiter in front of a shared downstream slave.
// Uncontended requests pass straight through; losers wait in a one-entry per-port buffer.
module ahb_cache_arbiter #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    output logic              src0_hready_resp,
    input  logic              src0_hready,
    output logic              src0_hresp,
    input  logic [W_ADDR-1:0] src0_haddr,
    input  logic              src0_hwrite,
    input  logic [1:0]        src0_htrans,
    input  logic [2:0]        src0_hsize,
    input  logic [3:0]        src0_hprot,
    input  logic [W_DATA-1:0] src0_hwdata,
    output logic [W_DATA-1:0] src0_hrdata,

    output logic              src1_hready_resp,
    input  logic              src1_hready,
    output logic              src1_hresp,
    input  logic [W_ADDR-1:0] src1_haddr,
    input  logic              src1_hwrite,
    input  logic [1:0]        src1_htrans,
    input  logic [2:0]        src1_hsize,
    input  logic [3:0]        src1_hprot,
    input  logic [W_DATA-1:0] src1_hwdata,
    output logic [W_DATA-1:0] src1_hrdata,

    input  logic              dst_hready_resp,
    output logic              dst_hready,
    input  logic              dst_hresp,
    output logic [W_ADDR-1:0] dst_haddr,
    output logic              dst_hwrite,
    output logic [1:0]        dst_htrans,
    output logic [2:0]        dst_hsize,
    output logic [3:0]        dst_hprot,
    output logic [W_DATA-1:0] dst_hwdata,
    input  logic [W_DATA-1:0] dst_hrdata
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic [W_ADDR-1:0] haddr;
        logic              hwrite;
        logic [2:0]        hsize;
        logic [3:0]        hprot;
    } req_t;

    req_t       live_req [2];
    req_t       buf_req  [2];
    req_t       sel_req;
    logic [1:0] live;
    logic [1:0] buf_valid;
    logic       grant_valid;
    logic       grant_port;
    logic       grant_buf;
    logic       contend;
    logic       owner_valid;
    logic       owner_port;
    logic       rr;

    // SEQ is treated as NONSEQ, so only htrans[1] matters.
    logic unused_htrans_lsb;
    assign unused_htrans_lsb = &{1'b0, src0_htrans[0], src1_htrans[0]};

    always_comb begin
        live_req[0] = '{haddr: src0_haddr, hwrite: src0_hwrite, hsize: src0_hsize, hprot: src0_hprot};
        live_req[1] = '{haddr: src1_haddr, hwrite: src1_hwrite, hsize: src1_hsize, hprot: src1_hprot};
        live[0]     = src0_hready & src0_htrans[1] & ~buf_valid[0];
        live[1]     = src1_hready & src1_htrans[1] & ~buf_valid[1];
    end

    // Buffered requests beat live ones; ties within a class go to the rr-favoured port.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        grant_buf   = 1'b0;
        contend     = 1'b0;
        if (rst_n && dst_hready_resp) begin
            if (buf_valid != 2'b00) begin
                grant_valid = 1'b1;
                grant_buf   = 1'b1;
                grant_port  = (buf_valid == 2'b11) ? rr : buf_valid[1];
            end else if (live != 2'b00) begin
                grant_valid = 1'b1;
                grant_port  = (live == 2'b11) ? rr : live[1];
            end
            // A port never has both a buffered and a live request, so two candidates means both ports.
            contend = &(buf_valid | live);
        end
    end

    always_comb begin
        sel_req = grant_buf ? buf_req[grant_port] : live_req[grant_port];
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid   <= 2'b00;
            owner_valid <= 1'b0;
            owner_port  <= 1'b0;
            rr          <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (grant_valid && grant_buf && (grant_port == n[0]))
                    buf_valid[n] <= 1'b0;
                else if (live[n] && !(grant_valid && !grant_buf && (grant_port == n[0])))
                    buf_valid[n] <= 1'b1;
            end
            if (dst_hready_resp) begin
                owner_valid <= grant_valid;
                owner_port  <= grant_port;
            end
            if (contend)
                rr <= ~grant_port;
        end
    end

    // NOTE: buffer payload has no reset; it is only ever read while its valid bit is set.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (live[n] && !(grant_valid && !grant_buf && (grant_port == n[0])))
                buf_req[n] <= live_req[n];
        end
    end

    always_comb begin
        dst_hready = dst_hready_resp;
        dst_htrans = grant_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
        dst_haddr  = sel_req.haddr;
        dst_hwrite = sel_req.hwrite;
        dst_hsize  = sel_req.hsize;
        dst_hprot  = sel_req.hprot;
        dst_hwdata = (owner_valid && owner_port) ? src1_hwdata : src0_hwdata;
    end

    always_comb begin
        src0_hrdata = dst_hrdata;
        src1_hrdata = dst_hrdata;
        src0_hresp  = rst_n & owner_valid & ~owner_port & dst_hresp;
        src1_hresp  = rst_n & owner_valid &  owner_port & dst_hresp;

        if (!rst_n)
            src0_hready_resp = 1'b1;
        else if (owner_valid && !owner_port)
            src0_hready_resp = dst_hready_resp;
        else
            src0_hready_resp = ~buf_valid[0];

        if (!rst_n)
            src1_hready_resp = 1'b1;
        else if (owner_valid && owner_port)
            src1_hready_resp = dst_hready_resp;
        else
            src1_hready_resp = ~buf_valid[1];
    end

endmodule

// File: tb/tb_ahb_cache_arbiter.sv
// Directed bench for ahb_cache_arbiter: expected downstream addresses are queued when
// requests are driven and popped whenever the arbiter issues an address phase.
module tb_ahb_cache_arbiter;

    localparam int W_ADDR = 32;
    localparam int W_DATA = 32;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic              clk;
    logic              rst_n;
    logic              src0_hready_resp, src1_hready_resp;
    logic              src0_hready, src1_hready;
    logic              src0_hresp, src1_hresp;
    logic [W_ADDR-1:0] src0_haddr, src1_haddr;
    logic              src0_hwrite, src1_hwrite;
    logic [1:0]        src0_htrans, src1_htrans;
    logic [2:0]        src0_hsize, src1_hsize;
    logic [3:0]        src0_hprot, src1_hprot;
    logic [W_DATA-1:0] src0_hwdata, src1_hwdata;
    logic [W_DATA-1:0] src0_hrdata, src1_hrdata;
    logic              dst_hready_resp, dst_hready, dst_hresp;
    logic [W_ADDR-1:0] dst_haddr;
    logic              dst_hwrite;
    logic [1:0]        dst_htrans;
    logic [2:0]        dst_hsize;
    logic [3:0]        dst_hprot;
    logic [W_DATA-1:0] dst_hwdata, dst_hrdata;

    int                n_assert = 0;
    int                n_fail   = 0;
    int                stall;
    logic [W_ADDR-1:0] exp_q [$];

    ahb_cache_arbiter #(.W_ADDR(W_ADDR), .W_DATA(W_DATA)) dut (
        .clk(clk), .rst_n(rst_n),
        .src0_hready_resp(src0_hready_resp), .src0_hready(src0_hready), .src0_hresp(src0_hresp),
        .src0_haddr(src0_haddr), .src0_hwrite(src0_hwrite), .src0_htrans(src0_htrans),
        .src0_hsize(src0_hsize), .src0_hprot(src0_hprot), .src0_hwdata(src0_hwdata),
        .src0_hrdata(src0_hrdata),
        .src1_hready_resp(src1_hready_resp), .src1_hready(src1_hready), .src1_hresp(src1_hresp),
        .src1_haddr(src1_haddr), .src1_hwrite(src1_hwrite), .src1_htrans(src1_htrans),
        .src1_hsize(src1_hsize), .src1_hprot(src1_hprot), .src1_hwdata(src1_hwdata),
        .src1_hrdata(src1_hrdata),
        .dst_hready_resp(dst_hready_resp), .dst_hready(dst_hready), .dst_hresp(dst_hresp),
        .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
        .dst_hsize(dst_hsize), .dst_hprot(dst_hprot), .dst_hwdata(dst_hwdata),
        .dst_hrdata(dst_hrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Settle combinational outputs, then score any downstream address phase in this cycle.
    task automatic sample();
        #1;
        if (dst_htrans == NONSEQ && dst_hready_resp) begin
            if (exp_q.size() == 0)
                check("spurious dst issue htrans", dst_htrans, IDLE);
            else
                check("dst issue haddr", dst_haddr, exp_q.pop_front());
        end
    endtask

    task automatic advance();
        @(negedge clk);
    endtask

    task automatic drive(input int p, input logic [1:0] tr, input logic [W_ADDR-1:0] a);
        if (p == 0) begin
            src0_htrans = tr;
            src0_haddr  = a;
        end else begin
            src1_htrans = tr;
            src1_haddr  = a;
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        src0_hready     = 1'b1;  src1_hready = 1'b1;
        src0_hwrite     = 1'b0;  src1_hwrite = 1'b0;
        src0_hsize      = 3'd2;  src1_hsize  = 3'd2;
        src0_hprot      = 4'h3;  src1_hprot  = 4'h1;
        src0_hwdata     = '0;    src1_hwdata = '0;
        dst_hready_resp = 1'b1;
        dst_hresp       = 1'b0;
        dst_hrdata      = '0;
        drive(0, NONSEQ, 32'h999);
        drive(1, IDLE, '0);

        // Reset: outputs forced even with a live request present
        sample();
        check("reset src0_hready_resp", src0_hready_resp, 1);
        check("reset src1_hready_resp", src1_hready_resp, 1);
        check("reset dst_htrans", dst_htrans, IDLE);
        check("reset src0_hresp", src0_hresp, 0);
        advance();
        rst_n = 1'b1;
        drive(0, IDLE, '0);
        sample();
        advance();

        // Single port, zero added latency
        drive(0, NONSEQ, 32'h100);
        exp_q.push_back(32'h100);
        sample();
        check("single dst_htrans", dst_htrans, NONSEQ);
        check("single src0_hready_resp addr", src0_hready_resp, 1);
        advance();
        drive(0, IDLE, '0);
        dst_hrdata = 32'hDEAD_0100;
        sample();
        check("single src0_hready_resp data", src0_hready_resp, 1);
        check("single src0_hrdata", src0_hrdata, 32'hDEAD_0100);
        check("single src0_hresp", src0_hresp, 0);
        advance();

        // Contention with rr at reset: port 0 first
        drive(0, NONSEQ, 32'h10);
        drive(1, NONSEQ, 32'h20);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h20);
        sample();
        check("contend1 src1_hready_resp addr", src1_hready_resp, 1);
        advance();
        drive(0, IDLE, '0);
        drive(1, IDLE, '0);
        sample();
        check("contend1 src1 stalled", src1_hready_resp, 0);
        check("contend1 src0_hready_resp", src0_hready_resp, 1);
        advance();
        sample();
        check("contend1 src1 released", src1_hready_resp, 1);
        check("contend1 dst idle", dst_htrans, IDLE);
        advance();

        // Repeat contention: port 1 first
        drive(0, NONSEQ, 32'h14);
        drive(1, NONSEQ, 32'h24);
        exp_q.push_back(32'h24);
        exp_q.push_back(32'h14);
        sample();
        advance();
        drive(0, IDLE, '0);
        drive(1, IDLE, '0);
        sample();
        check("contend2 src0 stalled", src0_hready_resp, 0);
        check("contend2 src1_hready_resp", src1_hready_resp, 1);
        advance();
        sample();
        check("contend2 src0 released", src0_hready_resp, 1);
        advance();

        // Downstream wait states while port 1 requests
        drive(0, NONSEQ, 32'h30);
        exp_q.push_back(32'h30);
        sample();
        advance();
        drive(0, IDLE, '0);
        drive(1, NONSEQ, 32'h40);
        exp_q.push_back(32'h40);
        dst_hready_resp = 1'b0;
        sample();
        check("wait dst_htrans idle", dst_htrans, IDLE);
        check("wait src0 owner stalled", src0_hready_resp, 0);
        check("wait src1 addr accepted", src1_hready_resp, 1);
        advance();
        drive(1, IDLE, '0);
        stall = 0;
        for (int i = 0; i < 4; i++) begin
            dst_hready_resp = (i >= 2);
            sample();
            if (!src1_hready_resp)
                stall++;
            if (i == 2)
                check("wait src0 completes", src0_hready_resp, 1);
            advance();
        end
        check("wait src1 data phase cycles", stall + 1, 4);

        // Two-cycle error to port 0 while port 1 gets buffered
        drive(0, NONSEQ, 32'h50);
        exp_q.push_back(32'h50);
        sample();
        advance();
        drive(0, IDLE, '0);
        drive(1, NONSEQ, 32'h60);
        exp_q.push_back(32'h60);
        dst_hready_resp = 1'b0;
        dst_hresp       = 1'b1;
        sample();
        check("err1 src0_hresp", src0_hresp, 1);
        check("err1 src0_hready_resp", src0_hready_resp, 0);
        check("err1 src1_hresp", src1_hresp, 0);
        advance();
        drive(1, IDLE, '0);
        dst_hready_resp = 1'b1;
        sample();
        check("err2 src0_hresp", src0_hresp, 1);
        check("err2 src0_hready_resp", src0_hready_resp, 1);
        check("err2 src1_hresp", src1_hresp, 0);
        check("err2 src1 stalled", src1_hready_resp, 0);
        advance();
        dst_hresp = 1'b0;
        sample();
        check("err3 src0_hresp", src0_hresp, 0);
        check("err3 src1_hresp", src1_hresp, 0);
        check("err3 src1_hready_resp", src1_hready_resp, 1);
        advance();

        // Reset mid-operation: port 0 owns, port 1 buffered and then discarded
        drive(0, NONSEQ, 32'h70);
        drive(1, NONSEQ, 32'h80);
        exp_q.push_back(32'h70);
        sample();
        advance();
        drive(0, IDLE, '0);
        drive(1, IDLE, '0);
        rst_n     = 1'b0;
        dst_hresp = 1'b1;
        sample();
        check("midrst src0_hready_resp", src0_hready_resp, 1);
        check("midrst src1_hready_resp", src1_hready_resp, 1);
        check("midrst dst_htrans", dst_htrans, IDLE);
        check("midrst src0_hresp", src0_hresp, 0);
        advance();
        rst_n     = 1'b1;
        dst_hresp = 1'b0;
        sample();
        check("postrst dst_htrans", dst_htrans, IDLE);
        check("postrst src1_hready_resp", src1_hready_resp, 1);
        check("postrst src0_hready_resp", src0_hready_resp, 1);
        advance();
        for (int i = 0; i < 3; i++) begin
            sample();
            advance();
        end
        check("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
